// File: rtl/ssp_rx_shifter.sv
// ssp_rx_shifter: receive front end for TI synchronous serial frames.
// Samples the asynchronous SSP pins on i_PCLK and deserialises each
// DATA_WIDTH-bit frame MSB first. Each finished byte is sent to the receive
// FIFO on o_RXDATA using a level o_REQ handshake.
//
// Handshake: o_REQ is a level request. It rises together with a new
// o_RXDATA value and stays high for exactly REQ_HOLD cycles. It then stays
// low for at least REQ_HOLD cycles. The receiver synchronises o_REQ and
// treats its rising edge as the write strobe. o_RXDATA stays unchanged from
// the o_REQ rise until the next accepted byte. A byte that finishes while the
// high or low phase is still running is dropped and flagged on o_RXOVR.
module ssp_rx_shifter #(
  parameter int DATA_WIDTH = 8,
  parameter int REQ_HOLD   = 4
) (
  input  logic                  i_PCLK,
  input  logic                  i_CLEAR_B,
  input  logic                  i_RXEN,
  input  logic                  i_SSPCLKIN,
  input  logic                  i_SSPFSSIN,
  input  logic                  i_SSPRXD,
  output logic [DATA_WIDTH-1:0] o_RXDATA,
  output logic                  o_REQ,
  output logic                  o_RXOVR,
  output logic                  o_BUSY
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam int HW = $clog2(2 * REQ_HOLD + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic                  sclk_meta, sclk_sync, sclk_dly;
  logic                  fss_meta, fss_sync;
  logic                  rxd_meta, rxd_sync;
  logic [0:0]            state;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-2:0] shift_q;
  logic [HW-1:0]         hs_cnt;

  logic                  sclk_fall;
  logic                  last_bit;
  logic                  byte_done;
  logic                  hs_busy;

  // Two-flop synchronisers on every pin, plus a delayed clock copy for edge detect
  always_ff @(posedge i_PCLK or negedge i_CLEAR_B) begin
    if (!i_CLEAR_B) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_dly  <= 1'b0;
      fss_meta  <= 1'b0;
      fss_sync  <= 1'b0;
      rxd_meta  <= 1'b0;
      rxd_sync  <= 1'b0;
    end else begin
      sclk_meta <= i_SSPCLKIN;
      sclk_sync <= sclk_meta;
      sclk_dly  <= sclk_sync;
      fss_meta  <= i_SSPFSSIN;
      fss_sync  <= fss_meta;
      rxd_meta  <= i_SSPRXD;
      rxd_sync  <= rxd_meta;
    end
  end

  assign sclk_fall = ~sclk_sync & sclk_dly;
  assign last_bit  = (bit_cnt == CW'(DATA_WIDTH - 1));
  assign byte_done = i_RXEN && sclk_fall && (state == ST_SHIFT) && last_bit;
  assign hs_busy   = (hs_cnt != '0);
  assign o_BUSY    = (state == ST_SHIFT);

  // Frame FSM. FSS on a falling edge marks the next edge as the MSB. A frame
  // that is cut short loses its partial byte. The shifter needs no clearing,
  // because a full frame rewrites every bit before it is used.
  always_ff @(posedge i_PCLK or negedge i_CLEAR_B) begin
    if (!i_CLEAR_B) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
    end else if (!i_RXEN) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
    end else if (sclk_fall) begin
      case (state)
        ST_IDLE: begin
          if (fss_sync) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (last_bit) begin
            bit_cnt <= '0;
            state   <= fss_sync ? ST_SHIFT : ST_IDLE;
          end else if (fss_sync) begin
            bit_cnt <= '0;
          end else begin
            shift_q <= {shift_q[DATA_WIDTH-3:0], rxd_sync};
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  // Handshake sequencer. hs_cnt counts down across the high phase and then
  // the low guard phase. o_REQ stays high while more than REQ_HOLD counts remain.
  always_ff @(posedge i_PCLK or negedge i_CLEAR_B) begin
    if (!i_CLEAR_B) begin
      o_RXDATA <= '0;
      o_REQ    <= 1'b0;
      o_RXOVR  <= 1'b0;
      hs_cnt   <= '0;
    end else begin
      o_RXOVR <= byte_done && hs_busy;
      if (byte_done && !hs_busy) begin
        o_RXDATA <= {shift_q, rxd_sync};
        o_REQ    <= 1'b1;
        hs_cnt   <= HW'(2 * REQ_HOLD - 1);
      end else if (hs_busy) begin
        hs_cnt <= hs_cnt - HW'(1);
        o_REQ  <= (hs_cnt > HW'(REQ_HOLD));
      end else begin
        o_REQ <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ssp_rx_shifter.sv
// Bench for ssp_rx_shifter. The stimulus drives the SSP pins frame by frame.
// Every complete frame pushes its byte and its LSB fall cycle into
// expectation queues. A monitor pops these entries on each o_REQ rise.
// A second instance with a long REQ_HOLD is used for the overrun case.
module tb_ssp_rx_shifter;

  logic       pclk = 1'b0;
  logic       clear_b;
  logic       rxen, rxen20;
  logic       sclk, fss, rxd;
  logic [7:0] rxdata, rxdata20;
  logic       req, req20, ovr, ovr20, busy, busy20;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         lat_q[$];
  int         lsb_cnt = 0;
  int         ovr_cnt = 0;
  int         req20_cnt = 0;
  int         ovr20_cnt = 0;
  logic [7:0] data20_first = 8'h00;

  // clock / reset
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  ssp_rx_shifter #(.DATA_WIDTH(8), .REQ_HOLD(4)) dut (
    .i_PCLK(pclk), .i_CLEAR_B(clear_b), .i_RXEN(rxen),
    .i_SSPCLKIN(sclk), .i_SSPFSSIN(fss), .i_SSPRXD(rxd),
    .o_RXDATA(rxdata), .o_REQ(req), .o_RXOVR(ovr), .o_BUSY(busy)
  );

  ssp_rx_shifter #(.DATA_WIDTH(8), .REQ_HOLD(20)) dut20 (
    .i_PCLK(pclk), .i_CLEAR_B(clear_b), .i_RXEN(rxen20),
    .i_SSPCLKIN(sclk), .i_SSPFSSIN(fss), .i_SSPRXD(rxd),
    .o_RXDATA(rxdata20), .o_REQ(req20), .o_RXOVR(ovr20), .o_BUSY(busy20)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks: one SSPCLK period. Data and FSS change on the rising pin edge.
  task automatic tick(input logic f, input logic d, input int half,
                      input logic push, input logic [7:0] b);
    @(negedge pclk);
    sclk = 1'b1;
    fss  = f;
    rxd  = d;
    repeat (half) @(negedge pclk);
    sclk = 1'b0;
    if (push) begin
      lsb_cnt++;
      if (rxen) begin
        exp_q.push_back(b);
        lat_q.push_back(cyc);
      end
    end
    repeat (half - 1) @(negedge pclk);
  endtask

  task automatic send_bits(input logic start, input int n, input int half);
    if (start) tick(1'b1, 1'($urandom_range(0, 1)), half, 1'b0, 8'h00);
    for (int i = 0; i < n; i++) tick(1'b0, 1'($urandom_range(0, 1)), half, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic start, input logic fss_last,
                            input int half);
    if (start) tick(1'b1, 1'($urandom_range(0, 1)), half, 1'b0, 8'h00);
    for (int i = 7; i >= 0; i--)
      tick((i == 0) ? fss_last : 1'b0, d[i], half, (i == 0), d);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || req) && n < 400) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 400) check({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
    repeat (12) @(negedge pclk);
  endtask

  // scoreboard monitor for the REQ_HOLD=4 instance
  initial begin : monitor
    logic       req_prev;
    int         width;
    logic [7:0] held;
    logic [7:0] e;
    int         l;
    req_prev = 1'b0;
    width    = 0;
    held     = 8'h00;
    forever begin
      @(negedge pclk);
      if (!clear_b) begin
        req_prev = 1'b0;
        width    = 0;
      end else begin
        if (ovr) ovr_cnt++;
        if (req && !req_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_req", 32'(rxdata), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            check("rxdata", 32'(rxdata), 32'(e));
            check("req_latency", 32'(cyc - l), 32'd3);
          end
          held  = rxdata;
          width = 1;
        end else if (req) begin
          width++;
          check("rxdata_stable", 32'(rxdata), 32'(held));
        end else if (req_prev) begin
          check("req_width", 32'(width), 32'd4);
        end
        req_prev = req;
      end
    end
  end

  // event counters for the REQ_HOLD=20 instance
  initial begin : monitor20
    logic req20_prev;
    req20_prev = 1'b0;
    forever begin
      @(negedge pclk);
      if (!clear_b) begin
        req20_prev = 1'b0;
      end else begin
        if (ovr20) ovr20_cnt++;
        if (req20 && !req20_prev) begin
          if (req20_cnt == 0) data20_first = rxdata20;
          req20_cnt++;
        end
        req20_prev = req20;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] a, b, d;
    int         gap, n, half, k;
    logic       b2b, prev_b2b;

    clear_b = 1'b0;
    rxen    = 1'b1;
    rxen20  = 1'b0;
    sclk    = 1'b1;
    fss     = 1'b0;
    rxd     = 1'b0;
    repeat (3) @(negedge pclk);
    check("reset_rxdata", 32'(rxdata), 32'd0);
    check("reset_req", 32'(req), 32'd0);
    check("reset_ovr", 32'(ovr), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_req20", 32'(req20), 32'd0);
    clear_b = 1'b1;
    repeat (3) @(negedge pclk);

    // 1: single frame at PCLK/8
    send_frame(8'hA5, 1'b1, 1'b0, 4);
    wait_idle("t1");
    check("t1_rxdata", 32'(rxdata), 32'hA5);

    // 2: back-to-back frames, BUSY must not drop between them
    lsb_cnt = 0;
    gap     = 0;
    fork
      begin
        send_frame(8'h3C, 1'b1, 1'b1, 4);
        send_frame(8'hC3, 1'b0, 1'b0, 4);
      end
      begin
        n = 0;
        while (!busy && n < 60) begin
          @(negedge pclk);
          n++;
        end
        check("t2_busy_seen", 32'(busy), 32'd1);
        while (lsb_cnt < 2) begin
          @(negedge pclk);
          if (!busy && lsb_cnt < 2) gap++;
        end
      end
    join
    check("t2_busy_gap", 32'(gap), 32'd0);
    wait_idle("t2");
    check("t2_rxdata", 32'(rxdata), 32'hC3);

    // 3: long hold, PCLK/4, back-to-back -> second byte overruns
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    rxen20 = 1'b1;
    send_frame(a, 1'b1, 1'b1, 2);
    send_frame(b, 1'b0, 1'b0, 2);
    repeat (60) @(negedge pclk);
    check("t3_req20_count", 32'(req20_cnt), 32'd1);
    check("t3_req20_data", 32'(data20_first), 32'(a));
    check("t3_ovr20_count", 32'(ovr20_cnt), 32'd1);
    check("t3_rxdata20_held", 32'(rxdata20), 32'(a));
    rxen20 = 1'b0;
    wait_idle("t3");

    // 4: RXEN dropped after 4 bits, then a clean frame
    send_bits(1'b1, 4, 4);
    repeat (4) @(negedge pclk);
    check("t4_busy_before", 32'(busy), 32'd1);
    rxen = 1'b0;
    @(negedge pclk);
    check("t4_busy_after", 32'(busy), 32'd0);
    repeat (6) @(negedge pclk);
    rxen = 1'b1;
    repeat (3) @(negedge pclk);
    send_frame(8'h81, 1'b1, 1'b0, 4);
    wait_idle("t4");
    check("t4_rxdata", 32'(rxdata), 32'h81);

    // 5: async reset mid-frame and while REQ is high
    send_bits(1'b1, 3, 4);
    @(negedge pclk);
    clear_b = 1'b0;
    #1;
    check("t5_mid_rxdata", 32'(rxdata), 32'd0);
    check("t5_mid_busy", 32'(busy), 32'd0);
    check("t5_mid_req", 32'(req), 32'd0);
    @(negedge pclk);
    clear_b = 1'b1;
    repeat (3) @(negedge pclk);
    send_frame(8'h55, 1'b1, 1'b0, 4);
    n = 0;
    while (!req && n < 40) begin
      @(negedge pclk);
      n++;
    end
    check("t5_req_seen", 32'(req), 32'd1);
    @(negedge pclk);
    clear_b = 1'b0;
    #1;
    check("t5_hs_req", 32'(req), 32'd0);
    check("t5_hs_rxdata", 32'(rxdata), 32'd0);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge pclk);
    clear_b = 1'b1;
    repeat (3) @(negedge pclk);
    send_frame(8'h7E, 1'b1, 1'b0, 4);
    wait_idle("t5");
    check("t5_rxdata", 32'(rxdata), 32'h7E);

    // 6: FSS re-pulsed after 3 bits, then a full frame
    send_bits(1'b1, 3, 4);
    send_frame(8'h5A, 1'b1, 1'b0, 4);
    wait_idle("t6");
    check("t6_rxdata", 32'(rxdata), 32'h5A);

    // random frames: random data, clock rates, back-to-back and resync prefixes
    prev_b2b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      d    = 8'($urandom_range(0, 255));
      half = $urandom_range(2, 5);
      b2b  = (i != 39) && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) begin
        k = $urandom_range(1, 6);
        send_bits(!prev_b2b, k, half);
        prev_b2b = 1'b0;
      end
      send_frame(d, !prev_b2b, b2b, half);
      prev_b2b = b2b;
      if (!b2b) repeat ($urandom_range(0, 6)) @(negedge pclk);
    end
    wait_idle("rand");

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("ovr_never", 32'(ovr_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
